had_trace_ctrl: RTL
===================

Name: had_trace_ctrl

Overview:
- Trace-counter and change-of-flow history stage of the HAD unit, directly upstream of the HAD debug-request control block.
- Counts retired instructions, or change-of-flow events, while trace mode is enabled. When the programmed count expires, raises the trace request that the control block turns into a debug entry.
- Also records the destination PCs of recent changes of flow in a small FIFO that the debugger reads through HAD registers.

Parameters:
- CNT_W, 8, trace counter width (TC register).
- HIST_DEPTH, 4, history FIFO entries; power of two, >=2.

Ports:
- had_clk  in  1  HAD clock.
- hadrst_b  in  1  asynchronous active-low reset.
- regs_trace_en  in  1  trace mode enable (HCR.TME).
- regs_trace_mode  in  1  event select: 0 = retired instruction, 1 = change of flow.
- regs_tc_wr  in  1  one-cycle write strobe for the trace counter.
- regs_tc_wdata  in  CNT_W  trace counter write data.
- regs_hist_rd  in  1  pop strobe for the oldest history entry.
- regs_hist_clr  in  1  flush the FIFO and clear the overflow flag.
- iu_had_inst_retire  in  1  an instruction retired this cycle.
- iu_had_chgflw_vld  in  1  change of flow this cycle.
- iu_had_chgflw_dst_pc  in  32  change-of-flow destination PC.
- iu_yy_xx_dbgon  in  1  core is in debug mode.
- had_yy_xx_exit_dbg  in  1  debug-exit pulse from the control block.
- iu_had_dbg_disable_for_tee  in  1  debug is disabled in the current TEE state.
- trace_req  out  1  trace debug request to the control block.
- trace_req_dbg_disable  out  1  trace expiry while debug is disabled.
- tc_value  out  CNT_W  current trace counter value.
- hist_rdata  out  32  oldest history entry.
- hist_vld  out  1  FIFO not empty.
- hist_cnt  out  $clog2(HIST_DEPTH)+1  FIFO occupancy.
- hist_ovf  out  1  sticky overflow flag.

Behaviour:
Reset values:
- All outputs are 0 and the FSM is in IDLE.
- tc = 0; FIFO empty with pointers at 0.

Event definition:
- evt = regs_trace_mode ? iu_had_chgflw_vld : iu_had_inst_retire.

FSM states and transitions:
- IDLE
  - Goes to COUNT when regs_trace_en && !iu_yy_xx_dbgon.
- COUNT
  - evt with tc <= 1: tc becomes 0 and the next state is REQ.
  - evt with tc > 1: tc decrements by 1.
  - regs_trace_en = 0: return to IDLE; tc is held.
- REQ
  - trace_req = !iu_had_dbg_disable_for_tee.
  - trace_req_dbg_disable = iu_had_dbg_disable_for_tee.
  - Both outputs are decoded from the registered state; the request is visible one cycle after the expiring event.
  - Held until iu_yy_xx_dbgon = 1, then go to WAIT_EXIT.
  - Held until regs_trace_en = 0, then go to IDLE with both requests dropped.
  - Further events are ignored.
- WAIT_EXIT
  - On had_yy_xx_exit_dbg: go to COUNT if regs_trace_en, otherwise IDLE.

Trace counter rules:
- regs_tc_wr loads tc = regs_tc_wdata in any state and takes priority over a same-cycle decrement.
- A write in REQ does not cancel the pending request.
- If tc = 0 on entry to COUNT, the first event goes to REQ (single-step behaviour).
- tc never wraps; it saturates at 0.
- tc_value = tc, registered.

History FIFO:
- Push when iu_had_chgflw_vld && regs_trace_en && !iu_yy_xx_dbgon.
- Pushed data is {iu_had_chgflw_dst_pc[31:1], 1'b0}.
- Push when full: overwrite the oldest entry (read pointer advances) and set hist_ovf.
- Pop when regs_hist_rd && hist_vld; a pop when empty is ignored.
- Push and pop in the same cycle:
  - Not full: occupancy is unchanged.
  - Full: occupancy is unchanged and hist_ovf is not set.
  - Empty: only the push takes effect.
- hist_rdata = mem[rd_ptr], a registered array read with no combinational path from the push data.
- Pointers are $clog2(HIST_DEPTH) bits and wrap naturally.
- regs_hist_clr has priority over a same-cycle push or pop: pointers, count and hist_ovf go to 0.

Reset mid-operation:
- An asynchronous reset returns the block to IDLE at once, drops trace_req, and clears tc and the FIFO.

Decomposition:
- Shared HAD package holds:
  - the FSM state encoding, localparam 2-bit: IDLE = 0, COUNT = 1, REQ = 2, WAIT_EXIT = 3;
  - the CNT_W default.
- One sub-module, had_trace_hist_fifo (HIST_DEPTH x 32 overwrite-on-full FIFO with clear), instantiated once.

Test Plan:
- Instruction mode:
  - Stimulus: tc = 3, trace_en = 1, mode = 0; retire on three consecutive cycles.
  - Required: tc goes 2, 1, 0; trace_req = 1 on the cycle after the third retire; trace_req held until dbgon = 1, then 0.
  - Then exit_dbg pulse: back in COUNT with tc = 0, and the next retire asserts trace_req.
- Change-of-flow mode:
  - Stimulus: mode = 1, tc = 2; five retires without chgflw, then two chgflw events.
  - Required: tc holds at 2 during the retires; trace_req asserts after the second chgflw.
- TEE disable:
  - Stimulus: tc = 1 with dbg_disable_for_tee = 1; one event.
  - Required: trace_req_dbg_disable = 1 and trace_req = 0.
- Counter write priority:
  - Stimulus: regs_tc_wr with wdata = 8'h10 on the same cycle as an event while tc = 5.
  - Required: tc = 8'h10.
- FIFO overflow:
  - Stimulus: five chgflw events with PCs 0x100, 0x205, 0x300, 0x400, 0x500 (DEPTH = 4).
  - Required: hist_ovf = 1 and hist_cnt = 4; pops return 0x204, 0x300, 0x400, 0x500, then hist_vld = 0.
- Reset and clear:
  - Stimulus: assert hadrst_b low while in REQ with two FIFO entries.
  - Required: trace_req = 0 and hist_cnt = 0 immediately (asynchronous); tc = 0 after release.
  - Separately: push and regs_hist_clr in the same cycle gives an empty FIFO.

Source files
------------

// File: rtl/had_trace_ctrl_pkg.sv
// Shared HAD definitions: trace FSM state encoding and trace counter width default.
package had_trace_ctrl_pkg;

  localparam int CNT_W_DFLT = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNT     = 2'd1,
    ST_REQ       = 2'd2,
    ST_WAIT_EXIT = 2'd3
  } trace_st_e;

endpackage

// File: rtl/had_trace_hist_fifo.sv
// Change-of-flow history FIFO; overwrites the oldest entry when full, clear wins over push/pop.
// Read data comes straight from the entry registers, so there is no path from push data to rd_dat_o.
module had_trace_hist_fifo
  import had_trace_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic        had_clk,
  input  logic        hadrst_b,
  input  logic        push_i,
  input  logic [31:0] push_dat_i,
  input  logic        pop_i,
  input  logic        clr_i,
  output logic [31:0] rd_dat_o,
  output logic        vld_o,
  output logic [PW:0] cnt_o,
  output logic        ovf_o
);

  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, do_pop, wr_en;

  assign full   = (cnt_q == FULL_CNT);
  assign empty  = (cnt_q == '0);
  assign do_pop = pop_i && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_i) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      // A push into a full FIFO drops the oldest entry, same as a pop would.
      if (do_pop || (push_i && full)) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && full && !do_pop) ovf_d = 1'b1;
      if (push_i && !full && !do_pop) cnt_d = cnt_q + 1'b1;
      else if (do_pop && !push_i)     cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge had_clk or negedge hadrst_b) begin
    if (!hadrst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      if (wr_en) mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign rd_dat_o = mem_q[rd_ptr_q];
  assign vld_o    = !empty;
  assign cnt_o    = cnt_q;
  assign ovf_o    = ovf_q;

endmodule

// File: rtl/had_trace_ctrl.sv
// HAD trace counter and change-of-flow history; the trace request follows the expiring event by one cycle.
// The request is held until the core enters debug or trace mode is disabled.
module had_trace_ctrl
  import had_trace_ctrl_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DFLT,
  parameter int HIST_DEPTH = 4
) (
  input  logic                          had_clk,
  input  logic                          hadrst_b,
  input  logic                          regs_trace_en,
  input  logic                          regs_trace_mode,
  input  logic                          regs_tc_wr,
  input  logic [CNT_W-1:0]              regs_tc_wdata,
  input  logic                          regs_hist_rd,
  input  logic                          regs_hist_clr,
  input  logic                          iu_had_inst_retire,
  input  logic                          iu_had_chgflw_vld,
  input  logic [31:0]                   iu_had_chgflw_dst_pc,
  input  logic                          iu_yy_xx_dbgon,
  input  logic                          had_yy_xx_exit_dbg,
  input  logic                          iu_had_dbg_disable_for_tee,
  output logic                          trace_req,
  output logic                          trace_req_dbg_disable,
  output logic [CNT_W-1:0]              tc_value,
  output logic [31:0]                   hist_rdata,
  output logic                          hist_vld,
  output logic [$clog2(HIST_DEPTH):0]   hist_cnt,
  output logic                          hist_ovf
);

  trace_st_e        state_q, state_d;
  logic [CNT_W-1:0] tc_q, tc_d;
  logic             evt;
  logic             hist_push;
  logic [31:0]      hist_push_dat;

  assign evt = regs_trace_mode ? iu_had_chgflw_vld : iu_had_inst_retire;

  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (regs_trace_en && !iu_yy_xx_dbgon) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (!regs_trace_en) begin
          state_d = ST_IDLE;
        end else if (evt) begin
          // tc of 0 on entry behaves like 1: the next event single-steps.
          if (tc_q <= CNT_W'(1)) begin
            tc_d    = '0;
            state_d = ST_REQ;
          end else begin
            tc_d = tc_q - CNT_W'(1);
          end
        end
      end
      ST_REQ: begin
        if (!regs_trace_en)      state_d = ST_IDLE;
        else if (iu_yy_xx_dbgon) state_d = ST_WAIT_EXIT;
      end
      ST_WAIT_EXIT: begin
        if (had_yy_xx_exit_dbg) state_d = regs_trace_en ? ST_COUNT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (regs_tc_wr) tc_d = regs_tc_wdata;
  end

  always_ff @(posedge had_clk or negedge hadrst_b) begin
    if (!hadrst_b) begin
      state_q <= ST_IDLE;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  assign trace_req             = (state_q == ST_REQ) && !iu_had_dbg_disable_for_tee;
  assign trace_req_dbg_disable = (state_q == ST_REQ) &&  iu_had_dbg_disable_for_tee;
  assign tc_value              = tc_q;

  assign hist_push     = iu_had_chgflw_vld && regs_trace_en && !iu_yy_xx_dbgon;
  assign hist_push_dat = iu_had_chgflw_dst_pc & 32'hFFFF_FFFE;

  had_trace_hist_fifo #(
    .DEPTH (HIST_DEPTH)
  ) u_hist_fifo (
    .had_clk    (had_clk),
    .hadrst_b   (hadrst_b),
    .push_i     (hist_push),
    .push_dat_i (hist_push_dat),
    .pop_i      (regs_hist_rd),
    .clr_i      (regs_hist_clr),
    .rd_dat_o   (hist_rdata),
    .vld_o      (hist_vld),
    .cnt_o      (hist_cnt),
    .ovf_o      (hist_ovf)
  );

endmodule
